fp_scoreboard_forwarding_unit: RTL and testbench

- Parametrised successor to the FP pipeline's combinational forwarding logic, for variable-latency FP units (FADD, FMUL, FDIV, FMA).
- Tracks in-flight FP destination registers with per-register countdown counters and books slots on the single FP writeback port.
- Each cycle, gives the ID stage a ready/stall decision and per-source forwarding selects for up to NUM_SRC sources (FMA needs rs3).
- Sits between FP decode/issue and the FP execution units.

---
 rtl/fp_sb_pkg.sv | 19 +
 rtl/fp_scoreboard_forwarding_unit_entry.sv | 37 +++
 rtl/fp_scoreboard_forwarding_unit.sv | 131 +++++++++++++
 tb/tb_fp_scoreboard_forwarding_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sb_pkg.sv
// Shared types and constants for the FP scoreboard / forwarding unit.
package fp_sb_pkg;

  // Operand source selection returned to the ID stage for each source.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // read the register file
    FWD_WB = 2'b01   // take the value from the writeback bus this cycle
  } fwd_sel_e;

  // Longest FP unit latency in the default configuration.
  localparam int DEF_MAX_LAT = 8;

  // Issue-to-writeback latencies of the FP execution units.
  localparam int LAT_FADD = 3;
  localparam int LAT_FMUL = 4;
  localparam int LAT_FMA  = 5;
  localparam int LAT_FDIV = 8;

endpackage

// File: rtl/fp_scoreboard_forwarding_unit_entry.sv
// One architectural register's in-flight state: a pending bit plus a
// countdown that reaches zero in the cycle the result is on the writeback bus.
module fp_sb_entry #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [CNT_W-1:0] set_cnt,
  output logic             pending,
  output logic [CNT_W-1:0] cnt
);

  logic             pending_reg;
  logic [CNT_W-1:0] cnt_reg;

  // A new issue overrides the clear/decrement of the current occupant.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (set) begin
      pending_reg <= 1'b1;
      cnt_reg     <= set_cnt;
    end else if (pending_reg) begin
      if (cnt_reg == '0) begin
        pending_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign pending = pending_reg;
  assign cnt     = cnt_reg;

endmodule

// File: rtl/fp_scoreboard_forwarding_unit.sv
// Scoreboard for variable-latency FP units: tracks in-flight destinations,
// books the single writeback port, and gives ID a ready flag plus per-source
// forwarding selects.
module fp_scoreboard_forwarding_unit
  import fp_sb_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int REG_AW         = 5,
  parameter int NUM_SRC        = 3,
  parameter int MAX_LAT        = DEF_MAX_LAT,
  parameter int CNT_W          = $clog2(MAX_LAT + 1),
  parameter int ZERO_HARDWIRED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_rd_wr,
  input  logic [CNT_W-1:0]          id_lat,
  output logic                      id_ready,
  output logic [NUM_SRC*2-1:0]      id_fwd_sel,
  input  logic                      wb_valid,
  input  logic [REG_AW-1:0]         wb_rd,
  output logic                      sb_busy,
  output logic                      sb_err
);

  genvar gi;

  logic [NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_SRC-1:0]  raw_vec;

  // Bit k of slot_reg: the writeback port is booked k cycles from now.
  // Bit 0 therefore means a result is due on the bus in the current cycle.
  logic [MAX_LAT:0] slot_reg;
  logic [MAX_LAT:0] slot_next;
  logic [MAX_LAT:0] issue_vec;
  logic             err_reg;

  logic             lat_bad;
  logic [CNT_W-1:0] eff_lat;
  logic             rd_tracked;
  logic             waw_hit;
  logic             struct_hit;
  logic             fire;
  logic             issue;
  logic             wb_due;
  logic             err_next;

  // Out-of-range latencies run as the slowest unit so the booking stays sane.
  assign lat_bad = (id_lat == '0) || (int'(id_lat) > MAX_LAT);
  assign eff_lat = lat_bad ? CNT_W'(MAX_LAT) : id_lat;

  // With a hardwired f0 a write to it books nothing and tracks nothing.
  assign rd_tracked = id_rd_wr && !((ZERO_HARDWIRED != 0) && (id_rd == '0));

  // The new write must finish strictly after the older one to the same rd.
  assign waw_hit    = rd_tracked && pending[id_rd] &&
                      (cnt[id_rd] >= (eff_lat - CNT_W'(1)));
  assign struct_hit = rd_tracked && slot_reg[eff_lat];

  // Per-source lookup: forward in the completion cycle, stall before it.
  for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_AW-1:0] idx;
    logic              live;
    assign idx  = id_src[gi*REG_AW +: REG_AW];
    assign live = id_src_used[gi] && pending[idx] &&
                  !((ZERO_HARDWIRED != 0) && (idx == '0));
    assign raw_vec[gi] = live && (cnt[idx] != '0);
    assign id_fwd_sel[gi*2 +: 2] = (live && (cnt[idx] == '0)) ? FWD_WB : FWD_RF;
  end

  assign id_ready = !(|raw_vec) && !waw_hit && !struct_hit;
  assign fire     = id_valid && id_ready;
  assign issue    = fire && rd_tracked;

  // One countdown entry per architectural register.
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    assign set_vec[gi] = issue && (id_rd == REG_AW'(gi));
    fp_sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .set     (set_vec[gi]),
      .set_cnt (eff_lat - CNT_W'(1)),
      .pending (pending[gi]),
      .cnt     (cnt[gi])
    );
  end

  // Book the slot L cycles out, then age every booking by one cycle.
  always_comb begin
    issue_vec = '0;
    if (issue) begin
      issue_vec[eff_lat] = 1'b1;
    end
    slot_next = (slot_reg | issue_vec) >> 1;
  end

  assign wb_due = slot_reg[0];

  // Protocol errors: bad latency on a write, a writeback nobody booked or for
  // an idle register, and a booked slot that passes with an empty bus. A
  // register overwritten by a later WAW issue legitimately sees the older
  // result while its own countdown is still running, so the writeback is
  // judged against the booking rather than that register's count.
  always_comb begin
    err_next = err_reg;
    if (fire && id_rd_wr && lat_bad) err_next = 1'b1;
    if (wb_valid && (!pending[wb_rd] || !wb_due)) err_next = 1'b1;
    if (wb_due && !wb_valid) err_next = 1'b1;
  end

  // Slot bookings and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      slot_reg <= slot_next;
      err_reg  <= err_next;
    end
  end

  assign sb_busy = |pending;
  assign sb_err  = err_reg;

endmodule

// File: tb/tb_fp_scoreboard_forwarding_unit.sv
// Directed scoreboard bench: every stimulus cycle pushes the expected
// {id_ready, id_fwd_sel, sb_busy, sb_err} word, which is popped and compared
// when the DUT outputs are sampled on the falling edge.
module tb_fp_scoreboard_forwarding_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  localparam logic [8:0] ALL = 9'h1FF;
  localparam logic [8:0] NONE = 9'h000;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid;
  logic [3*REG_AW-1:0] id_src;
  logic [2:0]          id_src_used;
  logic [REG_AW-1:0]   id_rd;
  logic                id_rd_wr;
  logic [CNT_W-1:0]    id_lat;
  logic                id_ready;
  logic [5:0]          id_fwd_sel;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_rd;
  logic                sb_busy;
  logic                sb_err;

  always #5 clk = ~clk;

  fp_scoreboard_forwarding_unit #(
    .NUM_REGS(32), .REG_AW(REG_AW), .NUM_SRC(3), .MAX_LAT(8),
    .CNT_W(CNT_W), .ZERO_HARDWIRED(1)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_lat(id_lat),
    .id_ready(id_ready), .id_fwd_sel(id_fwd_sel),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .sb_busy(sb_busy), .sb_err(sb_err)
  );

  typedef struct {
    string      tag;
    logic [8:0] val;
    logic [8:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   wb_at [0:511];
  int   cyc;
  int   n_checks;
  int   n_errors;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", tag, got, want);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  task automatic id_set(input logic v, input int s0, input int s1, input int s2,
                        input logic [2:0] used, input int rd, input logic wr, input int lat);
    id_valid    = v;
    id_src      = {REG_AW'(s2), REG_AW'(s1), REG_AW'(s0)};
    id_src_used = used;
    id_rd       = REG_AW'(rd);
    id_rd_wr    = wr;
    id_lat      = CNT_W'(lat);
  endtask

  task automatic idle();
    id_set(1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 0);
  endtask

  // Expected writeback of rd, lat cycles after the current cycle.
  task automatic book(input int rd, input int lat);
    wb_at[cyc + lat] = rd;
  endtask

  task automatic step(input string tag, input logic [8:0] want, input logic [8:0] mask);
    exp_t       e;
    logic [8:0] obs;
    if (wb_at[cyc] >= 0) begin
      wb_valid = 1'b1;
      wb_rd    = REG_AW'(wb_at[cyc]);
    end else begin
      wb_valid = 1'b0;
      wb_rd    = '0;
    end
    if (mask != NONE) begin
      e.tag  = tag;
      e.val  = want & mask;
      e.mask = mask;
      exp_q.push_back(e);
    end
    @(negedge clk);
    obs = {id_ready, id_fwd_sel, sb_busy, sb_err};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s@%0d", e.tag, cyc), obs & e.mask, e.val);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    for (int i = 0; i < 512; i++) wb_at[i] = -1;
    rst = 1'b1;
    idle();
    wb_valid = 1'b0;
    wb_rd    = '0;
    @(posedge clk);
    #1;
    step("rst", NONE, NONE);
    step("rst", NONE, NONE);
    rst = 1'b0;
    step("reset_state", 9'h100, ALL);

    // RAW stall then forward: FMUL f5 lat 4, FADD reads f5.
    id_set(1'b1, 0, 0, 0, 3'b000, 5, 1'b1, 4); book(5, 4);
    step("fmul_issue", 9'h100, ALL);
    id_set(1'b1, 5, 0, 0, 3'b001, 6, 1'b1, 3);
    repeat (3) step("raw_stall", 9'h002, ALL);
    book(6, 3);
    step("raw_fwd", 9'h106, ALL);
    id_set(1'b1, 5, 0, 0, 3'b001, 0, 1'b0, 3);
    step("raw_after", 9'h102, ALL);
    idle();
    step("raw_drain", 9'h102, ALL);
    step("raw_wb6", 9'h102, ALL);
    step("raw_idle", 9'h100, ALL);

    // Writeback structural conflict: FDIV lat 8, FMA lat 5 three cycles later.
    id_set(1'b1, 0, 0, 0, 3'b000, 2, 1'b1, 8); book(2, 8);
    step("fdiv_issue", 9'h100, ALL);
    idle();
    repeat (2) step("fdiv_busy", 9'h102, ALL);
    id_set(1'b1, 0, 0, 0, 3'b000, 7, 1'b1, 5);
    step("slot_clash", 9'h002, ALL);
    book(7, 5);
    step("slot_free", 9'h102, ALL);
    idle();
    repeat (5) step("slot_drain", 9'h102, ALL);
    step("slot_idle", 9'h100, ALL);

    // WAW: FDIV f9 lat 8 then FADD f9 lat 3 waits until cnt[9] < 2.
    id_set(1'b1, 0, 0, 0, 3'b000, 9, 1'b1, 8); book(9, 8);
    step("waw_fdiv", 9'h100, ALL);
    id_set(1'b1, 0, 0, 0, 3'b000, 9, 1'b1, 3);
    repeat (6) step("waw_stall", 9'h002, ALL);
    book(9, 3);
    step("waw_issue", 9'h102, ALL);
    idle();
    step("waw_wb_fdiv", 9'h102, ALL);
    step("waw_gap", 9'h102, ALL);
    step("waw_wb_fadd", 9'h102, ALL);
    step("waw_idle", 9'h100, ALL);

    // Hardwired f0 and unused sources.
    id_set(1'b1, 0, 0, 0, 3'b000, 5, 1'b1, 8); book(5, 8);
    step("z_rd5", 9'h100, ALL);
    id_set(1'b1, 0, 0, 0, 3'b000, 0, 1'b1, 4);
    step("z_rd0", 9'h102, ALL);
    id_set(1'b1, 0, 0, 5, 3'b011, 0, 1'b0, 0);
    step("z_read_f0", 9'h102, ALL);
    id_set(1'b1, 0, 0, 5, 3'b100, 0, 1'b0, 0);
    step("z_rs3_used", 9'h002, ALL);
    idle();
    repeat (5) step("z_drain", 9'h102, ALL);
    step("z_idle", 9'h100, ALL);

    // Latency 0 is clamped to the maximum and flagged.
    id_set(1'b1, 0, 0, 0, 3'b000, 3, 1'b1, 0); book(3, 8);
    step("clamp_issue", 9'h100, ALL);
    id_set(1'b1, 3, 0, 0, 3'b001, 0, 1'b0, 0);
    step("clamp_err", 9'h003, ALL);
    repeat (6) step("clamp_wait", 9'h003, ALL);
    step("clamp_fwd", 9'h107, ALL);
    idle();
    rst = 1'b1;
    step("rst", NONE, NONE);
    rst = 1'b0;
    step("clamp_rst", 9'h100, ALL);

    // Reset in the middle of three outstanding writes.
    id_set(1'b1, 0, 0, 0, 3'b000, 10, 1'b1, 8); book(10, 8);
    step("r_i10", 9'h100, ALL);
    id_set(1'b1, 0, 0, 0, 3'b000, 11, 1'b1, 6); book(11, 6);
    step("r_i11", 9'h102, ALL);
    id_set(1'b1, 0, 0, 0, 3'b000, 12, 1'b1, 7); book(12, 7);
    step("r_i12", 9'h102, ALL);
    idle();
    rst = 1'b1;
    for (int i = cyc; i < 512; i++) wb_at[i] = -1;
    step("rst", NONE, NONE);
    rst = 1'b0;
    id_set(1'b1, 10, 11, 12, 3'b111, 0, 1'b0, 0);
    step("r_after", 9'h100, ALL);
    idle();
    repeat (7) step("r_quiet", 9'h100, ALL);

    // Writeback to an idle register raises the sticky error.
    wb_at[cyc] = 12;
    step("bad_wb", 9'h100, ALL);
    repeat (3) step("err_hold", 9'h101, ALL);
    rst = 1'b1;
    step("rst", NONE, NONE);
    rst = 1'b0;
    step("err_clr", 9'h100, ALL);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
